fir_coeff_host: RTL and testbench

// Initiator side of the bit-serial FIR coefficient link (coeff_req/coeff_wr_op/coeff_wr_data/

---
 rtl/fir_coeff_host.sv | 124 ++++++++++++
 tb/tb_fir_coeff_host.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_host.sv
// Initiator side of the bit-serial FIR coefficient link: takes parallel read/write
// commands, serialises {addr,data}, runs the req/ack handshake and reports completion.
//
// state | meaning
// IDLE  | ready for a command
// REQ   | coeff_req raised, waiting for coeff_ack high
// ADR   | shifting address bits out
// WR    | shifting write data out
// RD    | sampling read data in
// REL   | coeff_req dropped, waiting for coeff_ack low
// DONE  | one-cycle success response
// ABORT | one-cycle timeout response
module fir_coeff_host #(
  parameter int ADDR_W  = 1,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              OSC_60MHZ,
  input  logic              RESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_adr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              coeff_req,
  output logic              coeff_wr_op,
  output logic              coeff_wr_data,
  input  logic              coeff_rd_data,
  input  logic              coeff_ack
);

  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [2:0] {IDLE, REQ, ADR, WR, RD, REL, DONE, ABORT} state_t;

  state_t             state, state_nxt;
  logic [FRAME_W-1:0] tx_sh;
  logic [DATA_W-1:0]  rx_sh;
  logic [CNT_W-1:0]   bit_cnt;
  logic [7:0]         tmo_cnt;
  logic               tmo_hit, last_adr, last_bit;

  assign tmo_hit  = (tmo_cnt == 8'(TIMEOUT - 1));
  assign last_adr = (bit_cnt == CNT_W'(ADDR_W - 1));
  assign last_bit = (bit_cnt == CNT_W'(FRAME_W - 1));

  always_ff @(posedge OSC_60MHZ or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (cmd_valid) state_nxt = REQ;
      REQ: begin
        if (coeff_ack)    state_nxt = ADR;
        else if (tmo_hit) state_nxt = ABORT;
      end
      ADR:   if (last_adr) state_nxt = coeff_wr_op ? WR : RD;
      WR:    if (last_bit) state_nxt = REL;
      RD:    if (last_bit) state_nxt = REL;
      REL: begin
        if (!coeff_ack)   state_nxt = DONE;
        else if (tmo_hit) state_nxt = ABORT;
      end
      DONE:    state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Timeout counter only runs while waiting on an ack edge; every other state parks it at 0
  // so REL starts its own fresh window.
  always_ff @(posedge OSC_60MHZ or posedge RESET) begin
    if (RESET) begin
      tx_sh       <= '0;
      rx_sh       <= '0;
      bit_cnt     <= '0;
      tmo_cnt     <= '0;
      coeff_wr_op <= 1'b0;
      rsp_data    <= '0;
    end else begin
      tmo_cnt <= '0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            tx_sh       <= {cmd_adr, cmd_data};
            coeff_wr_op <= cmd_wr;
            bit_cnt     <= '0;
          end
        end
        REQ: tmo_cnt <= tmo_cnt + 8'd1;
        ADR, WR: begin
          tx_sh   <= tx_sh << 1;
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        RD: begin
          rx_sh   <= {rx_sh[DATA_W-2:0], coeff_rd_data};
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        REL: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (!coeff_ack && !coeff_wr_op) rsp_data <= rx_sh;
        end
        default: ;
      endcase
    end
  end

  // coeff_req is decoded from state so an async reset drops it immediately.
  always_comb begin
    cmd_ready     = (state == IDLE);
    coeff_req     = (state == REQ) || (state == ADR) || (state == WR) || (state == RD);
    coeff_wr_data = ((state == ADR) || (state == WR)) && tx_sh[FRAME_W-1];
    rsp_valid     = (state == DONE) || (state == ABORT);
    rsp_err       = (state == ABORT);
  end

endmodule

// File: tb/tb_fir_coeff_host.sv
// Directed bench for fir_coeff_host; the bench itself plays the link responder.
module tb_fir_coeff_host;

  localparam int ADDR_W = 1;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_wr = 1'b0;
  logic [ADDR_W-1:0] cmd_adr = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              coeff_req;
  logic              coeff_wr_op;
  logic              coeff_wr_data;
  logic              coeff_rd_data = 1'b0;
  logic              coeff_ack = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc;
  logic [64:0] tx;

  fir_coeff_host #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(255)) dut (
    .OSC_60MHZ(clk), .RESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_adr(cmd_adr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .coeff_req(coeff_req), .coeff_wr_op(coeff_wr_op), .coeff_wr_data(coeff_wr_data),
    .coeff_rd_data(coeff_rd_data), .coeff_ack(coeff_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present one command for a single accept cycle; returns at the first REQ cycle.
  task automatic issue(input string tag, input logic wr, input logic [ADDR_W-1:0] adr,
                       input logic [DATA_W-1:0] data);
    cmd_wr = wr; cmd_adr = adr; cmd_data = data; cmd_valid = 1'b1;
    check({tag, "_ready"}, cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    check({tag, "_op"}, coeff_wr_op, wr);
  endtask

  // Responder: ack after 'delay' REQ cycles, capture 65 serial bits, drive read word.
  task automatic xfer(input string tag, input int delay, input logic [63:0] rd_word,
                      input logic drop_mid, output logic [64:0] bits);
    coeff_ack = 1'b0;
    repeat (delay) step();
    coeff_ack = 1'b1;
    step();
    for (int i = 0; i <= 64; i++) begin
      bits[64-i] = coeff_wr_data;
      coeff_rd_data = (i >= 1) ? rd_word[64-i] : 1'b0;
      if (drop_mid && i == 20) coeff_ack = 1'b0;
      if (i == 32) check({tag, "_req_mid"}, coeff_req, 1'b1);
      step();
    end
    coeff_rd_data = 1'b0;
    check({tag, "_req_rel"}, coeff_req, 1'b0);
  endtask

  task automatic release_ok(input string tag);
    coeff_ack = 1'b0;
    step();
    check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    check({tag, "_rsp_err"}, rsp_err, 1'b0);
    step();
    check({tag, "_rsp_clear"}, rsp_valid, 1'b0);
    check({tag, "_idle_ready"}, cmd_ready, 1'b1);
  endtask

  initial begin
    step();
    step();
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_err", rsp_err, 1'b0);
    check("rst_data", rsp_data, 64'h0);
    check("rst_req", coeff_req, 1'b0);
    check("rst_op", coeff_wr_op, 1'b0);
    check("rst_wdata", coeff_wr_data, 1'b0);
    rst = 1'b0;
    step();

    // 1: write, ack after 3 REQ cycles
    issue("t1", 1'b1, 1'b1, 64'hDEAD_BEEF_0123_4567);
    check("t1_req", coeff_req, 1'b1);
    xfer("t1", 3, 64'h0, 1'b0, tx);
    check("t1_bits", tx, {1'b1, 64'hDEAD_BEEF_0123_4567});
    release_ok("t1");

    // 2: read, ack dropped mid-frame must not abort
    issue("t2", 1'b0, 1'b0, 64'h0);
    xfer("t2", 0, 64'hA5A5_0000_FFFF_1234, 1'b1, tx);
    check("t2_adr_bits", tx, 65'h0);
    release_ok("t2");
    check("t2_rdata", rsp_data, 64'hA5A5_0000_FFFF_1234);

    // 3: no ack -> abort after 255 REQ cycles
    issue("t3", 1'b0, 1'b1, 64'h0);
    repeat (254) step();
    check("t3_req_last", coeff_req, 1'b1);
    step();
    check("t3_req_drop", coeff_req, 1'b0);
    check("t3_valid", rsp_valid, 1'b1);
    check("t3_err", rsp_err, 1'b1);
    check("t3_notready", cmd_ready, 1'b0);
    check("t3_data_kept", rsp_data, 64'hA5A5_0000_FFFF_1234);
    step();
    check("t3_ready", cmd_ready, 1'b1);
    check("t3_valid_clr", rsp_valid, 1'b0);

    // 4: ack stuck high after frame -> REL timeout, then clean write
    issue("t4", 1'b1, 1'b0, 64'h1);
    xfer("t4", 0, 64'h0, 1'b0, tx);
    repeat (254) step();
    check("t4_rel_wait", rsp_valid, 1'b0);
    step();
    check("t4_valid", rsp_valid, 1'b1);
    check("t4_err", rsp_err, 1'b1);
    coeff_ack = 1'b0;
    step();
    check("t4_ready", cmd_ready, 1'b1);
    issue("t4b", 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF);
    xfer("t4b", 1, 64'h0, 1'b0, tx);
    check("t4b_bits", tx, {1'b1, 64'h0123_4567_89AB_CDEF});
    release_ok("t4b");

    // 5: reset at bit 30 of a write
    issue("t5", 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    coeff_ack = 1'b1;
    step();
    repeat (30) step();
    rst = 1'b1;
    #1;
    check("t5_req_async", coeff_req, 1'b0);
    check("t5_wdata_async", coeff_wr_data, 1'b0);
    step();
    check("t5_no_valid", rsp_valid, 1'b0);
    check("t5_data_clr", rsp_data, 64'h0);
    rst = 1'b0;
    coeff_ack = 1'b0;
    step();
    issue("t5b", 1'b0, 1'b1, 64'h0);
    xfer("t5b", 2, 64'h0F1E_2D3C_4B5A_6978, 1'b0, tx);
    check("t5b_adr", tx[64], 1'b1);
    release_ok("t5b");
    check("t5b_rdata", rsp_data, 64'h0F1E_2D3C_4B5A_6978);

    // 6: back-to-back with cmd_valid held; second command has ack already high
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_adr = 1'b0; cmd_data = 64'hFEDC_BA98_7654_3210;
    check("t6_ready", cmd_ready, 1'b1);
    acc_cyc = cyc;
    step();
    check("t6_op1", coeff_wr_op, 1'b1);
    cmd_wr = 1'b0; cmd_adr = 1'b1; cmd_data = 64'h0;
    xfer("t6", 0, 64'h0, 1'b0, tx);
    check("t6_bits", tx, {1'b0, 64'hFEDC_BA98_7654_3210});
    coeff_ack = 1'b0;
    step();
    check("t6_valid1", rsp_valid, 1'b1);
    check("t6_busy", cmd_ready, 1'b0);
    // counted inclusive of both the accept cycle and the rsp_valid cycle
    check("t6_latency", 65'(cyc - acc_cyc + 1), 65'(ADDR_W + DATA_W + 4));
    coeff_ack = 1'b1;
    step();
    check("t6_accept2", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    check("t6_req2", coeff_req, 1'b1);
    check("t6_op2", coeff_wr_op, 1'b0);
    xfer("t6b", 0, 64'h5555_AAAA_3C3C_C3C3, 1'b0, tx);
    check("t6b_adr", tx[64], 1'b1);
    release_ok("t6b");
    check("t6b_rdata", rsp_data, 64'h5555_AAAA_3C3C_C3C3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
